// File: rtl/float_to_fixed_pkg.sv
// Shared types and IEEE-754 format helpers for the float-to-fixed pipeline.
package float_to_fixed_pkg;

  typedef enum logic {
    RM_TRUNC = 1'b0,
    RM_RNE   = 1'b1
  } round_mode_e;

  typedef struct packed {
    logic ovf;
    logic nan;
  } lane_flags_t;

  function automatic int exp_w(input bit is_single);
    return is_single ? 8 : 11;
  endfunction

  function automatic int man_w(input bit is_single);
    return is_single ? 23 : 52;
  endfunction

  function automatic int bias(input bit is_single);
    return is_single ? 127 : 1023;
  endfunction

endpackage

// File: rtl/float_to_fixed_lane.sv
// One lane of the converter: unpack/classify, align with guard/sticky,
// then round, negate and saturate. Stage enables come from the top.
module float_to_fixed_lane
  import float_to_fixed_pkg::*;
#(
  parameter int FLOAT      = 1,
  parameter int DATA_WIDTH = 20,
  parameter int FRAC_WIDTH = 12,
  localparam int IN_WIDTH  = (FLOAT != 0) ? 32 : 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en1,
  input  logic                  en2,
  input  logic                  en3,
  input  logic [IN_WIDTH-1:0]   a,
  input  logic                  keep,
  input  round_mode_e           rm,
  output logic [DATA_WIDTH-1:0] out,
  output lane_flags_t           flags
);

  localparam int EW   = exp_w(FLOAT != 0);
  localparam int MW   = man_w(FLOAT != 0);
  localparam int BIAS = bias(FLOAT != 0);
  localparam int TW   = DATA_WIDTH + MW + 2;

  localparam logic [DATA_WIDTH+1:0] LIM     = (DATA_WIDTH+2)'(1) << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [EW-1:0] exp_f;
  logic [MW-1:0] frac_f;

  assign exp_f  = a[IN_WIDTH-2 -: EW];
  assign frac_f = a[MW-1:0];

  logic               s1_sign, s1_zero, s1_inf, s1_nan;
  logic [MW:0]        s1_mant;
  logic signed [15:0] s1_shift;

  // Subnormals are classed with zero so they flush without a flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_mant  <= '0;
      s1_shift <= '0;
    end else if (en1) begin
      s1_sign  <= a[IN_WIDTH-1];
      s1_zero  <= (exp_f == '0);
      s1_inf   <= (exp_f == '1) && (frac_f == '0);
      s1_nan   <= (exp_f == '1) && (frac_f != '0);
      s1_mant  <= {1'b1, frac_f};
      s1_shift <= 16'(int'(exp_f) - BIAS + FRAC_WIDTH);
    end
  end

  logic [DATA_WIDTH:0] mag_c;
  logic                guard_c, sticky_c, range_c;

  // shift is the weight of the hidden bit in LSB units; anything past
  // DATA_WIDTH is far beyond the saturation threshold.
  always_comb begin : align
    int            sh;
    int            sh2;
    int            r;
    logic [TW-1:0] wide;
    sh       = int'(s1_shift);
    sh2      = sh - MW;
    r        = MW - sh;
    wide     = '0;
    guard_c  = 1'b0;
    sticky_c = 1'b0;
    if (sh2 >= 0) begin
      wide = TW'(s1_mant) << sh2;
    end else begin
      wide = TW'(s1_mant) >> r;
      for (int j = 0; j <= MW; j++) begin
        if (j == r - 1)
          guard_c = guard_c | s1_mant[j];
        else if (j < r - 1)
          sticky_c = sticky_c | s1_mant[j];
      end
    end
    mag_c   = wide[DATA_WIDTH:0];
    range_c = (sh > DATA_WIDTH) || (|wide[TW-1:DATA_WIDTH+1]);
  end

  logic                s2_sign, s2_zero, s2_inf, s2_nan;
  logic [DATA_WIDTH:0] s2_mag;
  logic                s2_guard, s2_sticky, s2_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_inf    <= 1'b0;
      s2_nan    <= 1'b0;
      s2_mag    <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_range  <= 1'b0;
    end else if (en2) begin
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_inf    <= s1_inf;
      s2_nan    <= s1_nan;
      s2_mag    <= mag_c;
      s2_guard  <= guard_c;
      s2_sticky <= sticky_c;
      s2_range  <= range_c;
    end
  end

  logic                  round_up;
  logic [DATA_WIDTH+1:0] rounded;
  logic [DATA_WIDTH-1:0] res_c;
  lane_flags_t           flags_c;

  assign round_up = (rm == RM_RNE) && s2_guard && (s2_sticky || s2_mag[0]);
  assign rounded  = {1'b0, s2_mag} + {{(DATA_WIDTH+1){1'b0}}, round_up};

  // Negative side may reach exactly LIM in magnitude; positive may not.
  always_comb begin
    res_c   = '0;
    flags_c = '0;
    if (!keep) begin
      res_c = '0;
    end else if (s2_nan) begin
      flags_c.nan = 1'b1;
    end else if (s2_zero) begin
      res_c = '0;
    end else if (s2_inf || s2_range || (s2_sign ? (rounded > LIM) : (rounded >= LIM))) begin
      res_c       = s2_sign ? MIN_NEG : MAX_POS;
      flags_c.ovf = 1'b1;
    end else begin
      res_c = s2_sign ? -rounded[DATA_WIDTH-1:0] : rounded[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      flags <= '0;
    end else if (en3) begin
      out   <= res_c;
      flags <= flags_c;
    end
  end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// Multi-lane float-to-fixed converter with a three-stage elastic pipeline
// and ready/valid flow control on both sides.
module float_to_fixed_pipe
  import float_to_fixed_pkg::*;
#(
  parameter int FLOAT       = 1,
  parameter int DATA_WIDTH  = 20,
  parameter int FRAC_WIDTH  = 12,
  parameter int PARALLELISM = 4,
  localparam int IN_WIDTH   = (FLOAT != 0) ? 32 : 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   round_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_tlast,
  input  logic [PARALLELISM-1:0] in_mask,
  input  logic [IN_WIDTH-1:0]    a [PARALLELISM],
  output logic [DATA_WIDTH-1:0]  out [PARALLELISM],
  output logic                   valid,
  input  logic                   ready,
  output logic                   tlast,
  output logic [PARALLELISM-1:0] tkeep,
  output logic [PARALLELISM-1:0] ovf,
  output logic [PARALLELISM-1:0] nan
);

  logic v1, v2, v3;
  logic en1, en2, en3;

  // A stage may load when it is empty or its successor is moving.
  assign en3      = !v3 || ready;
  assign en2      = !v2 || en3;
  assign en1      = !v1 || en2;
  assign in_ready = en1;
  assign valid    = v3;

  round_mode_e            rm1, rm2;
  logic [PARALLELISM-1:0] mask1, mask2;
  logic                   last1, last2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      rm1   <= RM_TRUNC;
      rm2   <= RM_TRUNC;
      mask1 <= '0;
      mask2 <= '0;
      last1 <= 1'b0;
      last2 <= 1'b0;
      tkeep <= '0;
      tlast <= 1'b0;
    end else begin
      if (en1) begin
        v1    <= in_valid;
        rm1   <= round_mode_e'(round_mode);
        mask1 <= in_mask;
        last1 <= in_tlast;
      end
      if (en2) begin
        v2    <= v1;
        rm2   <= rm1;
        mask2 <= mask1;
        last2 <= last1;
      end
      if (en3) begin
        v3    <= v2;
        tkeep <= mask2;
        tlast <= last2;
      end
    end
  end

  lane_flags_t lane_flags [PARALLELISM];

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    float_to_fixed_lane #(
      .FLOAT      (FLOAT),
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en1   (en1),
      .en2   (en2),
      .en3   (en3),
      .a     (a[i]),
      .keep  (mask2[i]),
      .rm    (rm2),
      .out   (out[i]),
      .flags (lane_flags[i])
    );
    assign ovf[i] = lane_flags[i].ovf;
    assign nan[i] = lane_flags[i].nan;
  end

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Directed-vector bench for float_to_fixed_pipe (binary32, Q7.12, 4 lanes)
// with stall, reset and random-ready streaming sequences.
module tb_float_to_fixed_pipe;

  localparam int P  = 4;
  localparam int DW = 20;
  localparam int N  = 20;

  logic          clk = 1'b0;
  logic          rst, round_mode, in_valid, in_ready, in_tlast;
  logic          valid, ready, tlast;
  logic [P-1:0]  in_mask, tkeep, ovf, nan;
  logic [31:0]   a   [P];
  logic [DW-1:0] out [P];

  always #5 clk = ~clk;

  float_to_fixed_pipe #(
    .FLOAT(1), .DATA_WIDTH(DW), .FRAC_WIDTH(12), .PARALLELISM(P)
  ) dut (
    .clk(clk), .rst(rst), .round_mode(round_mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_tlast(in_tlast), .in_mask(in_mask), .a(a),
    .out(out), .valid(valid), .ready(ready), .tlast(tlast), .tkeep(tkeep),
    .ovf(ovf), .nan(nan)
  );

  typedef struct {
    logic [31:0]   a;
    logic [DW-1:0] tr;
    logic [DW-1:0] rne;
    logic          ovf_tr;
    logic          ovf_rne;
    logic          nan;
  } vec_t;

  typedef struct packed {
    logic [P-1:0][DW-1:0] o;
    logic [P-1:0]         ovf;
    logic [P-1:0]         nan;
    logic [P-1:0]         keep;
    logic                 last;
  } beat_t;

  vec_t  vecs [N];
  beat_t exp_q [$];
  int    errors = 0;
  int    checks = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic beat_t expBeat(input logic [P-1:0][4:0] idx, input logic [P-1:0] mask,
                                    input logic rm, input logic last);
    beat_t b;
    vec_t  v;
    b = '0;
    for (int i = 0; i < P; i++) begin
      if (mask[i]) begin
        v        = vecs[idx[i]];
        b.o[i]   = rm ? v.rne : v.tr;
        b.ovf[i] = rm ? v.ovf_rne : v.ovf_tr;
        b.nan[i] = v.nan;
      end
    end
    b.keep = mask;
    b.last = last;
    return b;
  endfunction

  function automatic beat_t sampleBeat();
    beat_t b;
    for (int i = 0; i < P; i++) b.o[i] = out[i];
    b.ovf  = ovf;
    b.nan  = nan;
    b.keep = tkeep;
    b.last = tlast;
    return b;
  endfunction

  task automatic driveBeat(input logic [P-1:0][4:0] idx, input logic [P-1:0] mask,
                           input logic rm, input logic last);
    for (int i = 0; i < P; i++) a[i] = vecs[idx[i]].a;
    in_mask    = mask;
    round_mode = rm;
    in_tlast   = last;
  endtask

  // Presents one beat on an idle pipe and waits (bounded) for it to emerge.
  task automatic applyStimulus(input logic [P-1:0][4:0] idx, input logic [P-1:0] mask,
                               input logic rm, input logic last, output int lat);
    driveBeat(idx, mask, rm, last);
    in_valid = 1'b1;
    ready    = 1'b1;
    #1;
    checkOutput("in_ready_idle", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runStream(input int n_beats, input bit random_mode, input int cyc_limit);
    int                 sent = 0;
    int                 recv = 0;
    int                 cyc = 0;
    bit                 pending = 1'b0;
    bit                 hold_pending = 1'b0;
    beat_t              cur, held, e;
    logic [P-1:0][4:0]  idx;
    logic [P-1:0]       mask;
    logic               rm, last;
    idx = '0; mask = '0; rm = 1'b0; last = 1'b0; held = '0;
    exp_q.delete();
    while (recv < n_beats && cyc < cyc_limit) begin
      @(negedge clk);
      cur = sampleBeat();
      if (hold_pending) checkOutput("hold_stable", 128'(cur), 128'(held));
      if (!pending) in_valid = 1'b0;
      if (random_mode) ready = ($urandom_range(0, 3) != 0);
      else             ready = !(cyc >= 8 && cyc <= 12);
      if (!pending && sent < n_beats && (!random_mode || $urandom_range(0, 3) != 0)) begin
        for (int i = 0; i < P; i++)
          idx[i] = random_mode ? 5'($urandom_range(0, N-1)) : 5'((sent * 3 + i) % N);
        mask = random_mode ? 4'($urandom_range(0, 15)) : 4'hF;
        rm   = random_mode ? 1'($urandom_range(0, 1)) : sent[0];
        last = random_mode ? 1'($urandom_range(0, 1)) : (sent == n_beats - 1);
        driveBeat(idx, mask, rm, last);
        in_valid = 1'b1;
        pending  = 1'b1;
      end
      #1;
      if (!random_mode && cyc == 10) checkOutput("in_ready_full", 128'(in_ready), 128'(0));
      if (in_valid && in_ready) begin
        exp_q.push_back(expBeat(idx, mask, rm, last));
        sent++;
        pending = 1'b0;
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_beat: got %0h, expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("beat%0d", recv), 128'(cur), 128'(e));
        end
        recv++;
      end
      hold_pending = valid && !ready;
      held = cur;
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("beats_received", 128'(recv), 128'(n_beats));
  endtask

  initial begin
    int                lat;
    beat_t             got, ex;
    logic [P-1:0][4:0] idx;

    rst = 1'b1; in_valid = 1'b0; ready = 1'b1; in_mask = '0;
    round_mode = 1'b0; in_tlast = 1'b0;
    for (int i = 0; i < P; i++) a[i] = '0;

    vecs[0]  = '{32'h3FC00000, 20'h01800, 20'h01800, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'hC0100000, 20'hFDC00, 20'hFDC00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h80000000, 20'h00000, 20'h00000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h20000000, 20'h00000, 20'h00000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h39000000, 20'h00000, 20'h00000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h39C00000, 20'h00001, 20'h00002, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'hB9C00000, 20'hFFFFF, 20'hFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h43480000, 20'h7FFFF, 20'h7FFFF, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{32'hC3480000, 20'h80000, 20'h80000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{32'hC3000000, 20'h80000, 20'h80000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h7FC00000, 20'h00000, 20'h00000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'hFF800000, 20'h80000, 20'h80000, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{32'h7F800000, 20'h7FFFF, 20'h7FFFF, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{32'h43000000, 20'h7FFFF, 20'h7FFFF, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{32'h00400000, 20'h00000, 20'h00000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{32'h42FFFFF0, 20'h7FFFF, 20'h7FFFF, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{32'hC2FFFFF0, 20'h80001, 20'h80000, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{32'h3A200000, 20'h00002, 20'h00002, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{32'h3A600000, 20'h00003, 20'h00004, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{32'h7F000000, 20'h7FFFF, 20'h7FFFF, 1'b1, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("reset_valid", 128'(valid), 128'(0));
    checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
    checkOutput("reset_out0", 128'(out[0]), 128'(0));
    checkOutput("reset_tkeep", 128'(tkeep), 128'(0));
    rst = 1'b0;

    // Every vector in both rounding modes, rotated across the lanes.
    for (int v = 0; v < N; v++) begin
      for (int rm = 0; rm < 2; rm++) begin
        for (int i = 0; i < P; i++) idx[i] = 5'((v + i) % N);
        applyStimulus(idx, 4'hF, 1'(rm), 1'((v + rm) % 2), lat);
        got = sampleBeat();
        ex  = expBeat(idx, 4'hF, 1'(rm), 1'((v + rm) % 2));
        checkOutput($sformatf("latency_v%0d_rm%0d", v, rm), 128'(lat), 128'(3));
        for (int i = 0; i < P; i++)
          checkOutput($sformatf("out_v%0d_rm%0d_lane%0d", v, rm, i), 128'(got.o[i]), 128'(ex.o[i]));
        checkOutput($sformatf("flags_v%0d_rm%0d", v, rm), 128'({got.ovf, got.nan}), 128'({ex.ovf, ex.nan}));
        checkOutput($sformatf("tlast_v%0d_rm%0d", v, rm), 128'(got.last), 128'(ex.last));
      end
    end

    for (int i = 0; i < P; i++) idx[i] = 5'd7;
    applyStimulus(idx, 4'b0101, 1'b1, 1'b1, lat);
    checkOutput("mask_lane0", 128'(out[0]), 128'(20'h7FFFF));
    checkOutput("mask_lane1", 128'(out[1]), 128'(0));
    checkOutput("mask_lane3", 128'(out[3]), 128'(0));
    checkOutput("mask_flags", 128'({ovf, nan}), 128'({4'b0101, 4'b0000}));
    checkOutput("mask_tkeep", 128'(tkeep), 128'(4'b0101));
    checkOutput("mask_tlast", 128'(tlast), 128'(1));

    runStream(20, 1'b0, 200);

    // Three beats in flight, then reset: all must vanish.
    @(negedge clk);
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < P; i++) idx[i] = 5'(k);
      driveBeat(idx, 4'hF, 1'b1, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    ready    = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    checkOutput("midreset_valid", 128'(valid), 128'(0));
    checkOutput("midreset_in_ready", 128'(in_ready), 128'(1));
    checkOutput("midreset_out0", 128'(out[0]), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < P; i++) idx[i] = 5'(i + 5);
    applyStimulus(idx, 4'hF, 1'b1, 1'b1, lat);
    checkOutput("post_reset_latency", 128'(lat), 128'(3));
    checkOutput("post_reset_beat", 128'(sampleBeat()), 128'(expBeat(idx, 4'hF, 1'b1, 1'b1)));
    @(negedge clk);

    runStream(10000, 1'b1, 60000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
